// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: 24-hour timekeeper with clock-rate prescaler, 12h/24h
// display mapping, validated time-set handshake and second/day rollover
// pulses. Internal time is always kept in 24h form; the display mapping
// is purely combinational.
//
// Optional feature: define RTC_ALARM_EN to add an armed hh:mm:00 alarm
// comparator (ports alarm_arm, alarm_hours, alarm_minutes, alarm_hit).
module rtc_timekeeper #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRESC_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
`ifdef RTC_ALARM_EN
    input  logic       alarm_arm,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic       alarm_hit,
`endif
    output logic [4:0] hours,
    output logic       pm,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_pulse,
    output logic       day_rollover,
    output logic       set_error
);

    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc;
    logic [4:0]         h24;
    logic [5:0]         min_q;
    logic [5:0]         sec_q;

    logic               accept;
    logic               load_ok;
    logic               tick;

    logic [4:0]         nxt_h24;
    logic [5:0]         nxt_min;
    logic [5:0]         nxt_sec;
    logic               nxt_day_wrap;

    // Handshake and prescaler terminal-count decode
    always_comb begin
        accept  = set_valid && set_ready;
        load_ok = (set_hours <= 5'd23) && (set_minutes <= 6'd59) &&
                  (set_seconds <= 6'd59);
        tick    = run && (presc == PRESC_TC);
    end

    // Time one second ahead, with the sec -> min -> hour carry chain
    always_comb begin
        nxt_sec      = sec_q;
        nxt_min      = min_q;
        nxt_h24      = h24;
        nxt_day_wrap = 1'b0;
        if (sec_q == 6'd59) begin
            nxt_sec = '0;
            if (min_q == 6'd59) begin
                nxt_min = '0;
                if (h24 == 5'd23) begin
                    nxt_h24      = '0;
                    nxt_day_wrap = 1'b1;
                end else begin
                    nxt_h24 = h24 + 5'd1;
                end
            end else begin
                nxt_min = min_q + 6'd1;
            end
        end else begin
            nxt_sec = sec_q + 6'd1;
        end
    end

`ifdef RTC_ALARM_EN
    logic alarm_match;

    // Alarm matches only the tick-advanced time at hh:mm:00; the next-time
    // values are always in range, so out-of-range alarm settings never match
    always_comb begin
        alarm_match = alarm_arm && (nxt_sec == 6'd0) &&
                      (nxt_min == alarm_minutes) && (nxt_h24 == alarm_hours);
    end
`endif

    // Prescaler, time registers, handshake ready and event pulses.
    // A load takes priority over a tick on the same edge and suppresses
    // all tick-driven pulses; a rejected load also holds the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            h24          <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            sec_pulse    <= 1'b0;
            day_rollover <= 1'b0;
            set_error    <= 1'b0;
            set_ready    <= 1'b1;
`ifdef RTC_ALARM_EN
            alarm_hit    <= 1'b0;
`endif
        end else begin
            sec_pulse    <= 1'b0;
            day_rollover <= 1'b0;
            set_error    <= 1'b0;
            set_ready    <= 1'b1;
`ifdef RTC_ALARM_EN
            alarm_hit    <= 1'b0;
`endif
            if (accept) begin
                set_ready <= 1'b0;
                if (load_ok) begin
                    presc <= '0;
                    h24   <= set_hours;
                    min_q <= set_minutes;
                    sec_q <= set_seconds;
                end else begin
                    set_error <= 1'b1;
                end
            end else if (run) begin
                if (tick) begin
                    presc        <= '0;
                    h24          <= nxt_h24;
                    min_q        <= nxt_min;
                    sec_q        <= nxt_sec;
                    sec_pulse    <= 1'b1;
                    day_rollover <= nxt_day_wrap;
`ifdef RTC_ALARM_EN
                    alarm_hit    <= alarm_match;
`endif
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
        end
    end

    // Display mapping: 24h passthrough, or 12h with 0 -> 12 AM, 12 -> 12 PM
    always_comb begin
        minutes = min_q;
        seconds = sec_q;
        if (!mode_12h) begin
            hours = h24;
            pm    = 1'b0;
        end else begin
            pm = (h24 >= 5'd12);
            if (h24 == 5'd0) begin
                hours = 5'd12;
            end else if (h24 > 5'd12) begin
                hours = h24 - 5'd12;
            end else begin
                hours = h24;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Testbench for rtc_timekeeper (TICKS_PER_SEC=4): table-driven load/display
// vectors, hand-written multi-cycle sequences, and randomized stimulus
// checked every cycle against a seconds-of-day reference model.
module tb_rtc_timekeeper;

    localparam int TPS = 4;
    localparam int PW  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mode_12h;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic [4:0] hours;
    logic       pm;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_pulse;
    logic       day_rollover;
    logic       set_error;
`ifdef RTC_ALARM_EN
    logic       alarm_arm;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_hit;
`endif

    rtc_timekeeper #(
        .TICKS_PER_SEC(TPS),
        .PRESC_W      (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .mode_12h     (mode_12h),
        .set_valid    (set_valid),
        .set_ready    (set_ready),
        .set_hours    (set_hours),
        .set_minutes  (set_minutes),
        .set_seconds  (set_seconds),
`ifdef RTC_ALARM_EN
        .alarm_arm    (alarm_arm),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_hit    (alarm_hit),
`endif
        .hours        (hours),
        .pm           (pm),
        .minutes      (minutes),
        .seconds      (seconds),
        .sec_pulse    (sec_pulse),
        .day_rollover (day_rollover),
        .set_error    (set_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds of day, prescaler as a plain count
    int m_t, m_pc, m_ready, m_pulse, m_roll, m_err, m_hit;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_pc = 0; m_ready = 1; m_pulse = 0; m_roll = 0; m_err = 0; m_hit = 0;
    endtask

    // Apply one clock edge to the model using the inputs present at that edge
    task automatic model_edge();
        m_pulse = 0; m_roll = 0; m_err = 0; m_hit = 0;
        if (set_valid && m_ready != 0) begin
            m_ready = 0;
            if (int'(set_hours) < 24 && int'(set_minutes) < 60 && int'(set_seconds) < 60) begin
                m_t  = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                m_pc = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_ready = 1;
            if (run) begin
                m_pc++;
                if (m_pc == TPS) begin
                    m_pc    = 0;
                    m_t     = (m_t + 1) % 86400;
                    m_pulse = 1;
                    m_roll  = (m_t == 0) ? 1 : 0;
`ifdef RTC_ALARM_EN
                    if (alarm_arm && int'(alarm_hours) < 24 && int'(alarm_minutes) < 60 &&
                        m_t == int'(alarm_hours) * 3600 + int'(alarm_minutes) * 60)
                        m_hit = 1;
`endif
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        int h, eh, epm;
        h   = m_t / 3600;
        eh  = h;
        epm = 0;
        if (mode_12h) begin
            eh  = (h % 12 == 0) ? 12 : h % 12;
            epm = (h >= 12) ? 1 : 0;
        end
        chk({tag, ".hours"},     int'(hours),        eh);
        chk({tag, ".pm"},        int'(pm),           epm);
        chk({tag, ".minutes"},   int'(minutes),      (m_t / 60) % 60);
        chk({tag, ".seconds"},   int'(seconds),      m_t % 60);
        chk({tag, ".sec_pulse"}, int'(sec_pulse),    m_pulse);
        chk({tag, ".day_roll"},  int'(day_rollover), m_roll);
        chk({tag, ".set_error"}, int'(set_error),    m_err);
        chk({tag, ".set_ready"}, int'(set_ready),    m_ready);
`ifdef RTC_ALARM_EN
        chk({tag, ".alarm_hit"}, int'(alarm_hit),    m_hit);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model("model");
    endtask

    task automatic load(input int h, input int m, input int s);
        set_hours   = 5'(h);
        set_minutes = 6'(m);
        set_seconds = 6'(s);
        set_valid   = 1'b1;
        cycle();
        set_valid   = 1'b0;
    endtask

    typedef struct {
        int sh, sm, ss;
        bit mode;
        int exp_err, exp_h, exp_pm, exp_m, exp_s;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cnt;
        int hits;

        vecs[0] = '{ 0,  0,  0, 1'b1, 0, 12, 0,  0,  0};
        vecs[1] = '{11,  5,  7, 1'b1, 0, 11, 0,  5,  7};
        vecs[2] = '{12, 30,  0, 1'b1, 0, 12, 1, 30,  0};
        vecs[3] = '{13,  0, 59, 1'b1, 0,  1, 1,  0, 59};
        vecs[4] = '{23, 59, 59, 1'b1, 0, 11, 1, 59, 59};
        vecs[5] = '{24,  0,  0, 1'b0, 1, 23, 0, 59, 59};
        vecs[6] = '{10, 60,  0, 1'b0, 1, 23, 0, 59, 59};
        vecs[7] = '{ 9,  0, 60, 1'b1, 1, 11, 1, 59, 59};
        vecs[8] = '{31, 63, 63, 1'b0, 1, 23, 0, 59, 59};
        vecs[9] = '{ 0,  0,  1, 1'b0, 0,  0, 0,  0,  1};

        rst = 1'b1; run = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
        set_hours = '0; set_minutes = '0; set_seconds = '0;
`ifdef RTC_ALARM_EN
        alarm_arm = 1'b0; alarm_hours = '0; alarm_minutes = '0;
`endif
        model_reset();
        #2;
        check_model("reset");
        mode_12h = 1'b1;
        #1;
        chk("reset12.hours", int'(hours), 12);
        chk("reset12.pm",    int'(pm),    0);
        mode_12h = 1'b0;
        #9;
        rst = 1'b0;

        // Run into the second second, then reset asynchronously mid-count
        run = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst.seconds",   int'(seconds),   0);
        chk("async_rst.set_ready", int'(set_ready), 1);
        check_model("async_rst");
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 10 && cnt == 0; i++) begin
            cycle();
            if (sec_pulse) cnt = i;
        end
        chk("first_pulse.cycle",   cnt,           4);
        chk("first_pulse.seconds", int'(seconds), 1);

        // Day rollover from 23:59:58
        load(23, 59, 58);
        chk("roll.set_ready_low", int'(set_ready), 0);
        for (int i = 0; i < 8; i++) cycle();
        chk("roll.hours",   int'(hours),        0);
        chk("roll.minutes", int'(minutes),      0);
        chk("roll.seconds", int'(seconds),      0);
        chk("roll.pulse",   int'(sec_pulse),    1);
        chk("roll.day",     int'(day_rollover), 1);
        cycle();
        chk("roll.day_once", int'(day_rollover), 0);

        // Table: loads with display format, frozen time
        run = 1'b0;
        foreach (vecs[i]) begin
            mode_12h = vecs[i].mode;
            load(vecs[i].sh, vecs[i].sm, vecs[i].ss);
            chk("tbl.set_error", int'(set_error), vecs[i].exp_err);
            chk("tbl.set_ready", int'(set_ready), 0);
            chk("tbl.hours",     int'(hours),     vecs[i].exp_h);
            chk("tbl.pm",        int'(pm),        vecs[i].exp_pm);
            chk("tbl.minutes",   int'(minutes),   vecs[i].exp_m);
            chk("tbl.seconds",   int'(seconds),   vecs[i].exp_s);
            cycle();
            chk("tbl.ready_back", int'(set_ready), 1);
            chk("tbl.error_once", int'(set_error), 0);
        end

        // Mode toggle is visible without a clock edge
        load(23, 10, 0);
        cycle();
        #1 mode_12h = 1'b1;
        #1;
        chk("toggle12.hours", int'(hours), 11);
        chk("toggle12.pm",    int'(pm),    1);
        mode_12h = 1'b0;
        #1;
        chk("toggle24.hours", int'(hours), 23);
        chk("toggle24.pm",    int'(pm),    0);

        // Load on the tick edge wins; then freeze and resume
        run = 1'b1;
        load(10, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        load(5, 6, 7);
        chk("set_tick.pulse",   int'(sec_pulse), 0);
        chk("set_tick.seconds", int'(seconds),   7);
        chk("set_tick.hours",   int'(hours),     5);
        for (int i = 0; i < 2; i++) cycle();
        run = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("freeze.seconds", int'(seconds), 7);
        run = 1'b1;
        cycle();
        chk("resume.no_pulse", int'(sec_pulse), 0);
        cycle();
        chk("resume.pulse",   int'(sec_pulse), 1);
        chk("resume.seconds", int'(seconds),   8);

        // set_valid while not ready is ignored
        load(30, 0, 0);
        set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        chk("busy.no_error", int'(set_error), 0);

`ifdef RTC_ALARM_EN
        alarm_hours = 5'd7; alarm_minutes = 6'd30;
        for (int pass = 0; pass < 2; pass++) begin
            alarm_arm = (pass == 0);
            load(7, 29, 59);
            hits = 0; cnt = 0;
            for (int i = 1; i <= 8; i++) begin
                cycle();
                if (alarm_hit) begin hits++; cnt = i; end
            end
            chk("alarm.hits", hits, (pass == 0) ? 1 : 0);
            if (pass == 0) chk("alarm.cycle", cnt, 4);
        end
        alarm_arm = 1'b1;
        load(7, 30, 0);
        chk("alarm_load.hit", int'(alarm_hit), 0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (alarm_hit) hits++;
        end
        chk("alarm_load.hits", hits, 0);
        alarm_minutes = 6'd60;
        load(7, 59, 59);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (alarm_hit) hits++;
        end
        chk("alarm_range.hits", hits, 0);
`endif

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            run      = ($urandom_range(0, 9) != 0);
            mode_12h = $urandom_range(0, 1) == 1;
            set_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_hours   = 5'($urandom_range(22, 23));
                set_minutes = 6'($urandom_range(58, 59));
                set_seconds = 6'($urandom_range(50, 59));
            end else begin
                set_hours   = 5'($urandom_range(0, 31));
                set_minutes = 6'($urandom_range(0, 63));
                set_seconds = 6'($urandom_range(0, 63));
            end
`ifdef RTC_ALARM_EN
            alarm_arm     = $urandom_range(0, 3) != 0;
            alarm_hours   = 5'($urandom_range(0, 1) == 1 ? 0 : $urandom_range(0, 31));
            alarm_minutes = 6'($urandom_range(0, 1) == 1 ? 0 : $urandom_range(0, 63));
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
